// File: rtl/rs_latch_monitor.sv
// Observes a clocked view of an active-low RS latch, tracks its expected state and flags
// output mismatches once the inputs have been stable for SETTLE_CYC cycles.
module rs_latch_monitor #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sn,
  input  logic             rn,
  input  logic             q,
  input  logic             qn,
  input  logic             clr_err,
  output logic [1:0]       mon_state,
  output logic             exp_q,
  output logic             checking,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt,
  output logic             race
);

  typedef enum logic [1:0] {
    StUnknown = 2'b00,
    StSet     = 2'b01,
    StReset   = 2'b10,
    StForbid  = 2'b11
  } state_e;

  localparam logic [3:0] SettleInit = 4'(SETTLE_CYC);

  state_e           state_q, state_d;
  logic [1:0]       prev_in_q;
  logic [3:0]       settle_q, settle_d;
  logic             reported_q, reported_d;
  logic [1:0]       in_cur;
  logic             change, check_now, outputs_ok, mismatch;
  logic             race_d, pulse_d, sticky_d;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    in_cur    = {sn, rn};
    change    = (in_cur != prev_in_q);
    check_now = (settle_q == 4'd0) && !change;

    unique case (state_q)
      StSet:    outputs_ok = q && !qn;
      StReset:  outputs_ok = !q && qn;
      StForbid: outputs_ok = q && qn;
      default:  outputs_ok = (q != qn);
    endcase
    mismatch = check_now && !outputs_ok;

    state_d = state_q;
    race_d  = 1'b0;
    unique case (in_cur)
      2'b01: state_d = StSet;
      2'b10: state_d = StReset;
      2'b00: state_d = StForbid;
      default: begin
        if (state_q == StForbid) begin
          state_d = StUnknown;
          race_d  = 1'b1;
        end else if (state_q == StUnknown && check_now && (q != qn)) begin
          // A settled, consistent latch output tells us which way the race went.
          state_d = q ? StSet : StReset;
        end
      end
    endcase

    settle_d   = change ? SettleInit : ((settle_q == 4'd0) ? 4'd0 : settle_q - 4'd1);
    // A clr_err-dropped mismatch still counts as reported for this epoch.
    reported_d = change ? 1'b0 : (reported_q | mismatch);
    pulse_d    = mismatch && !reported_q && !clr_err;

    sticky_d = err_sticky;
    cnt_d    = err_cnt;
    if (clr_err) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end else if (pulse_d) begin
      sticky_d = 1'b1;
      if (err_cnt != {CNT_W{1'b1}}) cnt_d = err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StUnknown;
      prev_in_q  <= 2'b11;
      settle_q   <= SettleInit;
      reported_q <= 1'b0;
      exp_q      <= 1'b0;
      checking   <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      race       <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_in_q  <= in_cur;
      settle_q   <= settle_d;
      reported_q <= reported_d;
      exp_q      <= (state_d == StSet) || (state_d == StForbid);
      checking   <= check_now;
      err_pulse  <= pulse_d;
      err_sticky <= sticky_d;
      err_cnt    <= cnt_d;
      race       <= race_d;
    end
  end

  assign mon_state = state_q;

endmodule

// File: tb/tb_rs_latch_monitor.sv
// Scoreboard bench for rs_latch_monitor: a cycle-level reference model queues expected
// outputs per driven cycle, and a monitor compares them just after each rising edge.
module tb_rs_latch_monitor;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned CW     = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int UNK = 0, SET = 1, RST = 2, FORBID = 3;

  logic clk, rst_n, sn, rn, q, qn, clr_err;
  logic [1:0] mon_state;
  logic exp_q, checking, err_pulse, err_sticky, race;
  logic [CW-1:0] err_cnt;

  rs_latch_monitor #(.SETTLE_CYC(SETTLE), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .sn(sn), .rn(rn), .q(q), .qn(qn), .clr_err(clr_err),
    .mon_state(mon_state), .exp_q(exp_q), .checking(checking), .err_pulse(err_pulse),
    .err_sticky(err_sticky), .err_cnt(err_cnt), .race(race)
  );

  typedef struct {
    int st; bit eq; bit chk; bit ep; bit es; int cnt; bit rc;
  } exp_t;

  exp_t scoreboard[$];
  int checks = 0, failures = 0;
  int race_seen = 0, pulse_seen = 0;

  // Reference model: spec-level quantities (cycles since last input change, etc.)
  int m_st, m_prev, m_since, m_cnt;
  bit m_rep, m_sticky;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_st = UNK; m_prev = 3; m_since = 1; m_rep = 0; m_sticky = 0; m_cnt = 0;
  endtask

  task automatic apply(input bit s, input bit r, input bit qv, input bit qnv, input bit clr);
    exp_t e;
    int in, nst;
    bit chg, chk, ok, mism, pulse, rc;
    sn = s; rn = r; q = qv; qn = qnv; clr_err = clr;
    in  = {30'd0, s, r};
    chg = (in != m_prev);
    chk = !chg && (m_since > SETTLE);
    case (m_st)
      SET:     ok = qv && !qnv;
      RST:     ok = !qv && qnv;
      FORBID:  ok = qv && qnv;
      default: ok = (qv != qnv);
    endcase
    mism  = chk && !ok;
    pulse = mism && !m_rep && !clr;
    rc = 0;
    nst = m_st;
    if (in == 1) nst = SET;
    else if (in == 2) nst = RST;
    else if (in == 0) nst = FORBID;
    else if (m_st == FORBID) begin nst = UNK; rc = 1; end
    else if (m_st == UNK && chk && qv != qnv) nst = qv ? SET : RST;
    m_since = chg ? 1 : ((m_since < 100) ? m_since + 1 : m_since);
    m_rep   = chg ? 0 : (m_rep || mism);
    if (clr) begin
      m_sticky = 0; m_cnt = 0;
    end else if (pulse) begin
      m_sticky = 1;
      if (m_cnt < CMAX) m_cnt++;
    end
    m_prev = in;
    m_st   = nst;
    e.st = nst; e.eq = (nst == SET || nst == FORBID); e.chk = chk; e.ep = pulse;
    e.es = m_sticky; e.cnt = m_cnt; e.rc = rc;
    scoreboard.push_back(e);
  endtask

  task automatic drive(input bit s, input bit r, input bit qv, input bit qnv, input bit clr,
                       input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      apply(s, r, qv, qnv, clr);
    end
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic wait_checked();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " mon_state"}, int'(mon_state), 0);
    check({name, " exp_q"}, int'(exp_q), 0);
    check({name, " checking"}, int'(checking), 0);
    check({name, " err_pulse"}, int'(err_pulse), 0);
    check({name, " race"}, int'(race), 0);
    check({name, " err_sticky"}, int'(err_sticky), 0);
    check({name, " err_cnt"}, int'(err_cnt), 0);
  endtask

  // Monitor: every clocked cycle presents a full output vector.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (race) race_seen++;
    if (err_pulse) pulse_seen++;
    if (scoreboard.size() > 0) begin
      e = scoreboard.pop_front();
      checks++;
      if (int'(mon_state) != e.st || exp_q != e.eq || checking != e.chk || err_pulse != e.ep ||
          err_sticky != e.es || int'(err_cnt) != e.cnt || race != e.rc) begin
        failures++;
        $display("FAIL scoreboard t=%0t: got st=%0d eq=%0b chk=%0b ep=%0b es=%0b cnt=%0d rc=%0b expected st=%0d eq=%0b chk=%0b ep=%0b es=%0b cnt=%0d rc=%0b",
                 $time, mon_state, exp_q, checking, err_pulse, err_sticky, err_cnt, race,
                 e.st, e.eq, e.chk, e.ep, e.es, e.cnt, e.rc);
      end
    end
  end

  initial begin
    int r0, p0, pat, len;
    bit qv, qnv;
    rst_n = 1'b1; sn = 1'b1; rn = 1'b1; q = 1'b0; qn = 1'b1; clr_err = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 1, 0, 1, 0);

    // Set then hold
    r0 = race_seen;
    drive(0, 1, 1, 0, 0, 5);
    drive(1, 1, 1, 0, 0, 5);
    wait_checked();
    check("set_hold state", int'(mon_state), SET);
    check("set_hold err_cnt", int'(err_cnt), 0);
    check("set_hold race", race_seen - r0, 0);

    // Reset then hold
    drive(1, 0, 0, 1, 0, 5);
    drive(1, 1, 0, 1, 0, 5);
    wait_checked();
    check("reset_hold state", int'(mon_state), RST);
    check("reset_hold exp_q", int'(exp_q), 0);
    check("reset_hold sticky", int'(err_sticky), 0);

    // Forbidden then both released: race, then resolve from observed outputs
    r0 = race_seen;
    drive(0, 0, 1, 1, 0, 5);
    drive(1, 1, 0, 1, 0, 6);
    wait_checked();
    check("race pulses", race_seen - r0, 1);
    check("race resolved state", int'(mon_state), RST);
    check("race no error", int'(err_sticky), 0);

    // Single fault held for several checked cycles
    p0 = pulse_seen;
    drive(0, 1, 1, 0, 0, 5);
    drive(0, 1, 0, 0, 0, 6);
    wait_checked();
    check("fault pulses", pulse_seen - p0, 1);
    check("fault err_cnt", int'(err_cnt), 1);
    check("fault sticky", int'(err_sticky), 1);

    // Saturation, then clear coincident with a mismatch
    drive(0, 1, 1, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 1, 0, 4);
      drive(0, 1, 0, 1, 0, 5);
    end
    wait_checked();
    check("saturate err_cnt", int'(err_cnt), CMAX);
    drive(1, 0, 0, 1, 0, 4);
    p0 = pulse_seen;
    drive(0, 1, 0, 1, 0, 3);
    drive(0, 1, 0, 1, 1, 1);
    drive(0, 1, 0, 1, 0, 2);
    wait_checked();
    check("clear err_cnt", int'(err_cnt), 0);
    check("clear sticky", int'(err_sticky), 0);
    check("clear no pulse", pulse_seen - p0, 0);

    // Randomised traffic: mostly well-behaved latch, occasional faults and clears
    for (int k = 0; k < 120; k++) begin
      pat = $urandom_range(0, 3);
      len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        case (pat)
          1: begin qv = 1; qnv = 0; end
          2: begin qv = 0; qnv = 1; end
          0: begin qv = 1; qnv = 1; end
          default: begin
            if (m_st == SET) begin qv = 1; qnv = 0; end
            else if (m_st == RST) begin qv = 0; qnv = 1; end
            else begin qv = 1'($urandom_range(0, 1)); qnv = !qv; end
          end
        endcase
        if ($urandom_range(0, 99) < 15) begin
          qv = 1'($urandom_range(0, 1)); qnv = 1'($urandom_range(0, 1));
        end
        drive(pat[1], pat[0], qv, qnv, ($urandom_range(0, 99) < 4), 1);
      end
    end

    // Asynchronous reset between edges while in SET
    drive(0, 1, 1, 0, 0, 5);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1, 1, 1, 0, 0);
    drive(1, 1, 1, 0, 0, 5);
    drive(1, 0, 0, 1, 0, 6);
    wait_checked();
    check("post_reset state", int'(mon_state), RST);

    check("scoreboard drained", scoreboard.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
